// File: rtl/ctrl_pkg.sv
// Shared control-path types: opcodes, ALU-op codes and the per-stage control bundles.
package ctrl_pkg;

   localparam int unsigned CTRL_OP_W  = 6;
   localparam int unsigned CTRL_AOP_W = 3;
   localparam int unsigned CTRL_RA_W  = 5;

   localparam logic [CTRL_OP_W-1:0] OP_RTYPE = 6'b000000;
   localparam logic [CTRL_OP_W-1:0] OP_ADDI  = 6'b001000;
   localparam logic [CTRL_OP_W-1:0] OP_SLTI  = 6'b001010;
   localparam logic [CTRL_OP_W-1:0] OP_ANDI  = 6'b001100;
   localparam logic [CTRL_OP_W-1:0] OP_ORI   = 6'b001101;
   localparam logic [CTRL_OP_W-1:0] OP_LW    = 6'b100011;
   localparam logic [CTRL_OP_W-1:0] OP_SW    = 6'b101011;
   localparam logic [CTRL_OP_W-1:0] OP_BEQ   = 6'b000100;

   localparam logic [CTRL_AOP_W-1:0] AOP_LOAD  = 3'b000;
   localparam logic [CTRL_AOP_W-1:0] AOP_BEQ   = 3'b001;
   localparam logic [CTRL_AOP_W-1:0] AOP_RTYPE = 3'b010;
   localparam logic [CTRL_AOP_W-1:0] AOP_ADD   = 3'b011;
   localparam logic [CTRL_AOP_W-1:0] AOP_SLT   = 3'b100;
   localparam logic [CTRL_AOP_W-1:0] AOP_AND   = 3'b101;
   localparam logic [CTRL_AOP_W-1:0] AOP_OR    = 3'b110;
   localparam logic [CTRL_AOP_W-1:0] AOP_STORE = 3'b111;

   typedef struct packed {
      logic                  RegDs;
      logic                  Branch;
      logic                  MRead;
      logic                  MtoR;
      logic [CTRL_AOP_W-1:0] AOp;
      logic                  MWrite;
      logic                  ALUsrc;
      logic                  Urw;
      logic                  illegal;
   } ctrl_bundle_t;

   typedef struct packed {
      logic Branch;
      logic MRead;
      logic MWrite;
      logic MtoR;
      logic Urw;
   } ex_mem_t;

   typedef struct packed {
      logic MtoR;
      logic Urw;
   } mem_wb_t;

   localparam ctrl_bundle_t CTRL_NOP = '0;

   // Argument order matches the decode table columns so rows read straight across.
   function automatic ctrl_bundle_t mk_ctrl(logic regds, logic branch, logic mread, logic mtor,
                                            logic [CTRL_AOP_W-1:0] aop, logic mwrite,
                                            logic alusrc, logic urw);
      ctrl_bundle_t c;
      c = '{RegDs: regds, Branch: branch, MRead: mread, MtoR: mtor, AOp: aop,
            MWrite: mwrite, ALUsrc: alusrc, Urw: urw, illegal: 1'b0};
      return c;
   endfunction

endpackage

// File: rtl/ctrl_decode.sv
// ID-stage opcode decoder: pure combinational opcode -> control bundle.
module ctrl_decode
   import ctrl_pkg::*;
(
   input  logic [CTRL_OP_W-1:0] op_i,
   output ctrl_bundle_t         ctrl_o
);

   always_comb begin
      ctrl_o = CTRL_NOP;
      case (op_i)
         OP_RTYPE: ctrl_o = mk_ctrl(1'b1, 1'b0, 1'b0, 1'b1, AOP_RTYPE, 1'b0, 1'b0, 1'b1);
         OP_ADDI:  ctrl_o = mk_ctrl(1'b0, 1'b0, 1'b0, 1'b1, AOP_ADD,   1'b0, 1'b1, 1'b1);
         OP_SLTI:  ctrl_o = mk_ctrl(1'b0, 1'b0, 1'b0, 1'b1, AOP_SLT,   1'b0, 1'b1, 1'b1);
         OP_ANDI:  ctrl_o = mk_ctrl(1'b0, 1'b0, 1'b0, 1'b1, AOP_AND,   1'b0, 1'b1, 1'b1);
         OP_ORI:   ctrl_o = mk_ctrl(1'b0, 1'b0, 1'b0, 1'b1, AOP_OR,    1'b0, 1'b1, 1'b1);
         OP_LW:    ctrl_o = mk_ctrl(1'b0, 1'b0, 1'b1, 1'b1, AOP_LOAD,  1'b0, 1'b1, 1'b1);
         OP_SW:    ctrl_o = mk_ctrl(1'b0, 1'b0, 1'b0, 1'b0, AOP_STORE, 1'b1, 1'b1, 1'b0);
         OP_BEQ:   ctrl_o = mk_ctrl(1'b0, 1'b1, 1'b0, 1'b0, AOP_BEQ,   1'b0, 1'b0, 1'b0);
         default:  ctrl_o.illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipelined control unit: decode in ID, then ID/EX, EX/MEM, MEM/WB control registers with
// load-use stall/bubble, branch flush and a sticky illegal-opcode flag.
module pipe_ctrl_unit
   import ctrl_pkg::*;
#(
   parameter int unsigned OP_W      = CTRL_OP_W,
   parameter int unsigned AOP_W     = CTRL_AOP_W,
   parameter int unsigned RA_W      = CTRL_RA_W,
   parameter bit          HAZARD_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [OP_W-1:0]  id_op,
   input  logic [RA_W-1:0]  id_rs,
   input  logic [RA_W-1:0]  id_rt,
   input  logic [RA_W-1:0]  ex_rt,
   input  logic             flush,
   output logic             ex_RegDs,
   output logic [AOP_W-1:0] ex_AOp,
   output logic             ex_ALUsrc,
   output logic             mem_Branch,
   output logic             mem_MRead,
   output logic             mem_MWrite,
   output logic             wb_MtoR,
   output logic             wb_Urw,
   output logic             stall_o,
   output logic             illegal_o
);

   ctrl_bundle_t dec;
   ctrl_bundle_t idex_q, idex_d;
   ex_mem_t      exmem_q, exmem_d;
   mem_wb_t      memwb_q, memwb_d;
   logic         illegal_q;
   logic         stall;

   ctrl_decode u_dec (
      .op_i   (id_op),
      .ctrl_o (dec)
   );

   // Flush wins over stall: the load in EX is about to be killed anyway.
   generate
      if (HAZARD_EN) begin : g_hazard
         assign stall = ~flush & idex_q.MRead & (ex_rt != '0) &
                        ((ex_rt == id_rs) | (ex_rt == id_rt));
      end else begin : g_no_hazard
         assign stall = 1'b0;
      end
   endgenerate

   always_comb begin
      idex_d = dec;
      if (flush || stall) idex_d = CTRL_NOP;
      exmem_d = '{Branch: idex_q.Branch, MRead: idex_q.MRead, MWrite: idex_q.MWrite,
                  MtoR: idex_q.MtoR, Urw: idex_q.Urw};
      if (flush) exmem_d = '0;
      memwb_d = '{MtoR: exmem_q.MtoR, Urw: exmem_q.Urw};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idex_q    <= CTRL_NOP;
         exmem_q   <= '0;
         memwb_q   <= '0;
         illegal_q <= 1'b0;
      end else begin
         idex_q    <= idex_d;
         exmem_q   <= exmem_d;
         memwb_q   <= memwb_d;
         illegal_q <= illegal_q | idex_q.illegal;
      end
   end

   assign ex_RegDs   = idex_q.RegDs;
   assign ex_AOp     = idex_q.AOp;
   assign ex_ALUsrc  = idex_q.ALUsrc;
   assign mem_Branch = exmem_q.Branch;
   assign mem_MRead  = exmem_q.MRead;
   assign mem_MWrite = exmem_q.MWrite;
   assign wb_MtoR    = memwb_q.MtoR;
   assign wb_Urw     = memwb_q.Urw;
   assign stall_o    = stall;
   // Flag rises as soon as the illegal bundle sits in ID/EX, then holds via illegal_q.
   assign illegal_o  = illegal_q | idex_q.illegal;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench for pipe_ctrl_unit: decode latency, load-use stall, flush, illegal flag, reset.
module tb_pipe_ctrl_unit;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] id_op;
   logic [4:0] id_rs, id_rt, ex_rt;
   logic       flush;
   logic       ex_RegDs, ex_ALUsrc, mem_Branch, mem_MRead, mem_MWrite;
   logic       wb_MtoR, wb_Urw, stall_o, illegal_o;
   logic [2:0] ex_AOp;

   int n_chk = 0;
   int n_err = 0;

   pipe_ctrl_unit dut (
      .clk(clk), .rst(rst), .id_op(id_op), .id_rs(id_rs), .id_rt(id_rt), .ex_rt(ex_rt),
      .flush(flush), .ex_RegDs(ex_RegDs), .ex_AOp(ex_AOp), .ex_ALUsrc(ex_ALUsrc),
      .mem_Branch(mem_Branch), .mem_MRead(mem_MRead), .mem_MWrite(mem_MWrite),
      .wb_MtoR(wb_MtoR), .wb_Urw(wb_Urw), .stall_o(stall_o), .illegal_o(illegal_o)
   );

   always #5 clk = ~clk;

   localparam logic [5:0] R = 6'b000000, ADDI = 6'b001000, ORI = 6'b001101, LW = 6'b100011;
   localparam logic [5:0] SW = 6'b101011, BEQ = 6'b000100, BAD = 6'b111111;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [11:0] all_out();
      return {ex_RegDs, ex_AOp, ex_ALUsrc, mem_Branch, mem_MRead, mem_MWrite,
              wb_MtoR, wb_Urw, stall_o, illegal_o};
   endfunction

   // Stream table: ex AOp/ALUsrc, mem MWrite, wb Urw per instruction.
   logic [5:0] s_op   [6] = '{R, ADDI, SW, BEQ, ORI, ORI};
   logic [2:0] s_aop  [6] = '{3'b010, 3'b011, 3'b111, 3'b001, 3'b110, 3'b110};
   logic       s_src  [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
   logic       s_mw   [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
   logic       s_urw  [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

   initial begin
      rst = 1'b1; id_op = R; id_rs = '0; id_rt = '0; ex_rt = '0; flush = 1'b0;

      // 1: reset state, then first decode after release
      tick(); tick();
      chk("rst_all_zero", 32'(all_out()), 32'h0);
      rst = 1'b0;
      tick();
      chk("rel_ex_RegDs", 32'(ex_RegDs), 32'd1);
      chk("rel_ex_AOp", 32'(ex_AOp), 32'b010);

      // 2: stream R,ADDI,SW,BEQ,ORI,ORI
      for (int i = 0; i < 6; i++) begin
         id_op = s_op[i];
         tick();
         chk($sformatf("strm_ex_AOp%0d", i), 32'(ex_AOp), 32'(s_aop[i]));
         chk($sformatf("strm_ex_src%0d", i), 32'(ex_ALUsrc), 32'(s_src[i]));
         if (i >= 1) chk($sformatf("strm_mem_MW%0d", i), 32'(mem_MWrite), 32'(s_mw[i-1]));
         if (i >= 2) chk($sformatf("strm_wb_Urw%0d", i), 32'(wb_Urw), 32'(s_urw[i-2]));
      end

      // 3: load-use on rs
      id_op = LW; ex_rt = 5'd8;
      #1 chk("lu_no_stall_pre", 32'(stall_o), 32'd0);
      tick();
      chk("lu_ex_lw", 32'({ex_RegDs, ex_AOp, ex_ALUsrc}), 32'b0_000_1);
      id_op = ADDI; id_rs = 5'd8;
      #1 chk("lu_stall", 32'(stall_o), 32'd1);
      tick();
      chk("lu_bubble_ex", 32'({ex_RegDs, ex_AOp, ex_ALUsrc}), 32'h0);
      chk("lu_stall_drop", 32'(stall_o), 32'd0);
      chk("lu_mem_lw", 32'(mem_MRead), 32'd1);
      tick();
      chk("lu_ex_addi", 32'({ex_AOp, ex_ALUsrc}), 32'b011_1);
      chk("lu_mem_bubble", 32'(mem_MRead), 32'd0);
      chk("lu_wb_lw", 32'({wb_MtoR, wb_Urw}), 32'b11);

      // 4: register 0 never stalls; rt match does; no match doesn't
      id_op = LW; id_rs = '0; id_rt = '0; ex_rt = '0;
      tick();
      id_op = ADDI;
      #1 chk("r0_no_stall", 32'(stall_o), 32'd0);
      ex_rt = 5'd9; id_rt = 5'd9;
      #1 chk("rt_stall", 32'(stall_o), 32'd1);
      ex_rt = 5'd5; id_rs = 5'd3; id_rt = 5'd4;
      #1 chk("nomatch_no_stall", 32'(stall_o), 32'd0);

      // 5: flush beats stall while BEQ is in MEM
      id_op = BEQ; id_rs = '0; id_rt = '0; ex_rt = '0;
      tick();
      id_op = LW;
      tick();
      chk("fl_mem_branch", 32'(mem_Branch), 32'd1);
      id_op = ADDI; id_rs = 5'd8; ex_rt = 5'd8;
      #1 chk("fl_hazard_seen", 32'(stall_o), 32'd1);
      flush = 1'b1;
      #1 chk("fl_stall_masked", 32'(stall_o), 32'd0);
      tick();
      flush = 1'b0;
      chk("fl_ex_zero", 32'({ex_RegDs, ex_AOp, ex_ALUsrc}), 32'h0);
      chk("fl_mem_zero", 32'({mem_Branch, mem_MRead, mem_MWrite}), 32'h0);
      chk("fl_wb_beq", 32'({wb_MtoR, wb_Urw}), 32'h0);
      chk("fl_no_illegal", 32'(illegal_o), 32'd0);

      // 6: illegal opcode, sticky flag, mid-stream reset
      id_rs = '0; ex_rt = '0; id_op = BAD;
      tick();
      chk("ill_ex_zero", 32'({ex_RegDs, ex_AOp, ex_ALUsrc}), 32'h0);
      chk("ill_set", 32'(illegal_o), 32'd1);
      id_op = R;
      tick(); tick();
      chk("ill_held", 32'(illegal_o), 32'd1);
      chk("ill_next_R", 32'(ex_RegDs), 32'd1);
      rst = 1'b1;
      #1 chk("midrst_async", 32'(all_out()), 32'h0);
      tick();
      chk("midrst_hold", 32'(all_out()), 32'h0);
      id_op = ADDI; rst = 1'b0;
      tick();
      chk("rel2_ex_addi", 32'({ex_AOp, ex_ALUsrc}), 32'b011_1);
      chk("rel2_ill_clr", 32'(illegal_o), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
